// File: rtl/ssd_scan_mux.sv
// ssd_scan_mux: time-multiplexed seven-segment driver for NUM_DIGITS digits.
// Each digit owns a SCAN_DIV-cycle slot whose first BLANK_CYCLES cycles keep
// every anode dark to stop the previous digit's segments ghosting. Displayed
// values come from shadow registers that only reload at frame boundaries, so
// an update from the score logic never tears across a single frame.
module ssd_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 262144,
    parameter int BLANK_CYCLES = 1024,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    ClkPort,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   enable_mask,
    input  logic                    lzs_en,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [7:0]              seg_n,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    // Active-low abcdefg pattern for one hex nibble.
    function automatic logic [6:0] hex7_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            4'hF: seg = 7'b0111000;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]        cnt_r;
    logic                    load_pending_r;
    logic [4*NUM_DIGITS-1:0] sh_digits_r;
    logic [NUM_DIGITS-1:0]   sh_dp_r;
    logic [NUM_DIGITS-1:0]   sh_mask_r;

    logic                    wrap_s;
    logic                    frame_start_s;
    logic                    lit_window_s;
    logic [CNT_W-1:0]        cnt_nxt_s;
    logic [IDX_W-1:0]        idx_nxt_s;
    logic [NUM_DIGITS-1:0]   suppress_s;
    logic [NUM_DIGITS-1:0]   onehot_s;
    logic [3:0]              cur_nib_s;
    logic                    cur_dp_s;
    logic                    cur_mask_s;
    logic                    cur_supp_s;
    logic                    all_zero_s;

    // Slot counter wrap, digit advance and frame boundary detection.
    always_comb begin
        wrap_s        = (cnt_r == CNT_W'(SCAN_DIV - 1));
        frame_start_s = wrap_s & (digit_idx == IDX_W'(NUM_DIGITS - 1));
        cnt_nxt_s     = wrap_s ? {CNT_W{1'b0}} : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
        if (!wrap_s) begin
            idx_nxt_s = digit_idx;
        end else if (digit_idx == IDX_W'(NUM_DIGITS - 1)) begin
            idx_nxt_s = {IDX_W{1'b0}};
        end else begin
            idx_nxt_s = digit_idx + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        // cnt >= BLANK_CYCLES, written as cnt+1 > BLANK so BLANK=0 is not a constant compare
        lit_window_s = ({1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1}) > (CNT_W+1)'(BLANK_CYCLES);
    end

    // Leading-zero suppression mask: a digit is blank if it and everything above is zero.
    always_comb begin
        all_zero_s = 1'b1;
        suppress_s = {NUM_DIGITS{1'b0}};
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            all_zero_s    = all_zero_s & (sh_digits_r[4*k +: 4] == 4'd0);
            suppress_s[k] = lzs_en & all_zero_s;
        end
    end

    // Select the shadowed attributes of the digit in the current slot.
    always_comb begin
        cur_nib_s  = 4'd0;
        cur_dp_s   = 1'b0;
        cur_mask_s = 1'b0;
        cur_supp_s = 1'b0;
        onehot_s   = {NUM_DIGITS{1'b0}};
        for (int k = 0; k < NUM_DIGITS; k++) begin
            onehot_s[k] = (digit_idx == IDX_W'(k));
            cur_nib_s   = onehot_s[k] ? sh_digits_r[4*k +: 4] : cur_nib_s;
            cur_dp_s    = onehot_s[k] ? sh_dp_r[k]            : cur_dp_s;
            cur_mask_s  = onehot_s[k] ? sh_mask_r[k]          : cur_mask_s;
            cur_supp_s  = onehot_s[k] ? suppress_s[k]         : cur_supp_s;
        end
    end

    // Scan state: slot counter, digit index and frame pulse.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            cnt_r      <= {CNT_W{1'b0}};
            digit_idx  <= {IDX_W{1'b0}};
            frame_tick <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            digit_idx  <= idx_nxt_s;
            frame_tick <= frame_start_s;
        end
    end

    // Shadow capture at each frame start and on the first edge out of reset.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            load_pending_r <= 1'b1;
            sh_digits_r    <= {(4*NUM_DIGITS){1'b0}};
            sh_dp_r        <= {NUM_DIGITS{1'b0}};
            sh_mask_r      <= {NUM_DIGITS{1'b0}};
        end else begin
            load_pending_r <= 1'b0;
            if (frame_start_s || load_pending_r) begin
                sh_digits_r <= digits_in;
                sh_dp_r     <= dp_in;
                sh_mask_r   <= enable_mask;
            end
        end
    end

    // Registered pin drive from the current slot state.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            an_n  <= {NUM_DIGITS{1'b1}};
            seg_n <= 8'hFF;
        end else begin
            an_n  <= ~(onehot_s & {NUM_DIGITS{lit_window_s & cur_mask_s}});
            seg_n <= {(cur_supp_s ? 7'b1111111 : hex7_decode(cur_nib_s)), ~cur_dp_s};
        end
    end

endmodule
